// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: burst-buffer FSM encodings and burst-length helpers.
package sdram_pkg;

   typedef enum logic [1:0] {W_FILL, W_REQ, W_BUSY} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_FILL, R_DRAIN} rd_state_e;
   typedef enum logic [1:0] {H_NONE, H_WR, H_RD} arb_hold_e;

   function automatic bit bl_legal(input int unsigned bl);
      return (bl == 1) || (bl == 2) || (bl == 4) || (bl == 8);
   endfunction

   // Counter width for a burst index; a BL of 1 still gets a 1-bit counter.
   function automatic int unsigned cnt_w(input int unsigned bl);
      return (bl > 1) ? $clog2(bl) : 1;
   endfunction

endpackage

// File: rtl/sdram_burst_buf_if.sv
// User-side write-beat, read-address and read-data channels of the SDRAM burst buffer.
interface sdram_burst_buf_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 24
);
   logic [DATA_W-1:0]   wr_data;
   logic [DATA_W/8-1:0] wr_strb;
   logic [ADDR_W-1:0]   wr_addr;
   logic                wr_last;
   logic                wr_valid;
   logic                wr_ready;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_avalid;
   logic                rd_aready;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_last;
   logic                rd_valid;
   logic                rd_ready;

   modport master (
      output wr_data, wr_strb, wr_addr, wr_last, wr_valid, rd_addr, rd_avalid, rd_ready,
      input  wr_ready, rd_aready, rd_data, rd_last, rd_valid
   );

   modport slave (
      input  wr_data, wr_strb, wr_addr, wr_last, wr_valid, rd_addr, rd_avalid, rd_ready,
      output wr_ready, rd_aready, rd_data, rd_last, rd_valid
   );
endinterface

// File: rtl/sdram_rr_arb.sv
// Two-requester round-robin arbiter for the controller; a raised grant is held until acknowledged.
module sdram_rr_arb
   import sdram_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_wr,
   input  logic req_rd,
   input  logic ack_wr,
   input  logic ack_rd,
   input  logic busy,
   output logic gnt_wr,
   output logic gnt_rd
);
   arb_hold_e hold_q;
   logic      prio_rd_q;
   logic      contest;

   assign contest = (hold_q == H_NONE) && !busy && req_wr && req_rd;

   always_comb begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      case (hold_q)
         H_WR:    gnt_wr = 1'b1;
         H_RD:    gnt_rd = 1'b1;
         default: begin
            if (!busy) begin
               if (contest) begin
                  gnt_rd = prio_rd_q;
                  gnt_wr = !prio_rd_q;
               end else begin
                  gnt_wr = req_wr;
                  gnt_rd = req_rd;
               end
            end
         end
      endcase
   end

   // Priority flips only on contested decisions, so uncontested traffic does not skew alternation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= H_NONE;
         prio_rd_q <= 1'b1;
      end else begin
         if (gnt_wr && !ack_wr)      hold_q <= H_WR;
         else if (gnt_rd && !ack_rd) hold_q <= H_RD;
         else                        hold_q <= H_NONE;
         if (contest) prio_rd_q <= !prio_rd_q;
      end
   end
endmodule

// File: rtl/sdram_burst_buf.sv
// Burst buffer between a user beat stream and an SDRAM controller: one write and one read burst in flight.
module sdram_burst_buf
   import sdram_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned BL     = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   sdram_burst_buf_if.slave    usr,
   output logic                sd_wr_req,
   input  logic                sd_wr_ack,
   output logic [ADDR_W-1:0]   sd_wr_addr,
   input  logic                sd_wr_dvalid,
   input  logic                sd_wr_done,
   output logic [DATA_W-1:0]   sd_dq_o,
   output logic [DATA_W/8-1:0] sd_dqm_o,
   output logic                sd_dq_oe,
   output logic                sd_rd_req,
   input  logic                sd_rd_ack,
   output logic [ADDR_W-1:0]   sd_rd_addr,
   input  logic [DATA_W-1:0]   sd_dq_i,
   input  logic                sd_rd_dvalid,
   input  logic                sd_rd_done
);
   localparam int unsigned   CW       = cnt_w(BL);
   localparam int unsigned   SW       = DATA_W / 8;
   localparam logic [CW-1:0] LAST_IDX = CW'(BL - 1);
   localparam logic [CW:0]   FILL_END = (CW + 1)'(BL);

   if (!bl_legal(BL) || (DATA_W % 8) != 0) begin : g_param_check
      $error("sdram_burst_buf: BL must be 1, 2, 4 or 8 and DATA_W a multiple of 8");
   end

   wr_state_e ws_q, ws_d;
   rd_state_e rs_q, rs_d;
   logic [CW-1:0]     wcnt_q, pidx_q, dcnt_q;
   logic [CW:0]       fcnt_q;
   logic [ADDR_W-1:0] waddr_q, raddr_q;
   logic [DATA_W-1:0] wmem [BL];
   logic [SW-1:0]     wmsk [BL];
   logic [DATA_W-1:0] rmem [BL];
   logic wr_fire, wr_end, rd_fire, rd_end, wr_acc, rd_acc;
   logic wr_ready_c, dq_oe_c, rd_aready_c, rd_valid_c;

   assign wr_fire = (ws_q == W_FILL) && usr.wr_valid;
   assign wr_end  = wr_fire && ((wcnt_q == LAST_IDX) || usr.wr_last);
   assign rd_fire = (rs_q == R_DRAIN) && usr.rd_ready;
   assign rd_end  = rd_fire && (dcnt_q == LAST_IDX);
   assign wr_acc  = sd_wr_req && sd_wr_ack;
   assign rd_acc  = sd_rd_req && sd_rd_ack;

   sdram_rr_arb u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_wr (ws_q == W_REQ),
      .req_rd (rs_q == R_REQ),
      .ack_wr (sd_wr_ack),
      .ack_rd (sd_rd_ack),
      .busy   ((ws_q == W_BUSY) || (rs_q == R_FILL)),
      .gnt_wr (sd_wr_req),
      .gnt_rd (sd_rd_req)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws_q <= W_FILL;
         rs_q <= R_IDLE;
      end else begin
         ws_q <= ws_d;
         rs_q <= rs_d;
      end
   end

   always_comb begin
      ws_d        = ws_q;
      rs_d        = rs_q;
      wr_ready_c  = (ws_q == W_FILL);
      dq_oe_c     = (ws_q == W_BUSY);
      rd_aready_c = (rs_q == R_IDLE);
      rd_valid_c  = (rs_q == R_DRAIN);
      case (ws_q)
         W_FILL:  if (wr_end) ws_d = W_REQ;
         W_REQ:   if (wr_acc) ws_d = W_BUSY;
         W_BUSY:  if (sd_wr_done) ws_d = W_FILL;
         default: ws_d = W_FILL;
      endcase
      case (rs_q)
         R_IDLE:  if (usr.rd_avalid) rs_d = R_REQ;
         R_REQ:   if (rd_acc) rs_d = R_FILL;
         R_FILL:  if (sd_rd_done) rs_d = R_DRAIN;
         R_DRAIN: if (rd_end) rs_d = R_IDLE;
         default: rs_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q  <= '0;
         pidx_q  <= '0;
         fcnt_q  <= '0;
         dcnt_q  <= '0;
         waddr_q <= '0;
         raddr_q <= '0;
      end else begin
         if (wr_fire) begin
            wcnt_q <= wr_end ? '0 : wcnt_q + 1'b1;
            if (wcnt_q == '0) waddr_q <= usr.wr_addr;
         end
         if (ws_q == W_BUSY && sd_wr_done)
            pidx_q <= '0;
         else if (ws_q == W_BUSY && sd_wr_dvalid && pidx_q != LAST_IDX)
            pidx_q <= pidx_q + 1'b1;
         if (rs_q == R_IDLE && usr.rd_avalid) raddr_q <= usr.rd_addr;
         if (rs_q == R_FILL && sd_rd_done)
            fcnt_q <= '0;
         else if (rs_q == R_FILL && sd_rd_dvalid && fcnt_q != FILL_END)
            fcnt_q <= fcnt_q + 1'b1;
         if (rd_fire) dcnt_q <= rd_end ? '0 : dcnt_q + 1'b1;
      end
   end

   // Buffers are not reset; an early wr_last masks every entry above the final beat.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int unsigned i = 0; i < BL; i++) begin
            if (i == 32'(wcnt_q)) begin
               wmem[i] <= usr.wr_data;
               wmsk[i] <= ~usr.wr_strb;
            end else if (usr.wr_last && i > 32'(wcnt_q)) begin
               wmsk[i] <= '1;
            end
         end
      end
      if (rs_q == R_FILL && sd_rd_dvalid) begin
         for (int unsigned i = 0; i < BL; i++)
            if (i == 32'(fcnt_q)) rmem[i] <= sd_dq_i;
      end
   end

   assign usr.wr_ready  = wr_ready_c;
   assign usr.rd_aready = rd_aready_c;
   assign usr.rd_valid  = rd_valid_c;
   assign usr.rd_data   = rmem[dcnt_q];
   assign usr.rd_last   = rd_valid_c && (dcnt_q == LAST_IDX);
   assign sd_dq_oe      = dq_oe_c;
   assign sd_dq_o       = wmem[pidx_q];
   assign sd_dqm_o      = wmsk[pidx_q];
   assign sd_wr_addr    = waddr_q;
   assign sd_rd_addr    = raddr_q;
endmodule

// File: tb/tb_sdram_burst_buf.sv
// Directed and randomized burst-level checks of sdram_burst_buf, with the bench acting as user and controller.
`timescale 1ns/1ps
module tb_sdram_burst_buf;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 24;
   localparam int unsigned BL = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          sd_wr_req, sd_wr_ack, sd_wr_dvalid, sd_wr_done, sd_dq_oe;
   logic [AW-1:0] sd_wr_addr, sd_rd_addr;
   logic [DW-1:0] sd_dq_o, sd_dq_i;
   logic [1:0]    sd_dqm_o;
   logic          sd_rd_req, sd_rd_ack, sd_rd_dvalid, sd_rd_done;

   sdram_burst_buf_if #(.DATA_W(DW), .ADDR_W(AW)) u_if ();

   sdram_burst_buf #(.DATA_W(DW), .ADDR_W(AW), .BL(BL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .usr          (u_if),
      .sd_wr_req    (sd_wr_req),
      .sd_wr_ack    (sd_wr_ack),
      .sd_wr_addr   (sd_wr_addr),
      .sd_wr_dvalid (sd_wr_dvalid),
      .sd_wr_done   (sd_wr_done),
      .sd_dq_o      (sd_dq_o),
      .sd_dqm_o     (sd_dqm_o),
      .sd_dq_oe     (sd_dq_oe),
      .sd_rd_req    (sd_rd_req),
      .sd_rd_ack    (sd_rd_ack),
      .sd_rd_addr   (sd_rd_addr),
      .sd_dq_i      (sd_dq_i),
      .sd_rd_dvalid (sd_rd_dvalid),
      .sd_rd_done   (sd_rd_done)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: what the user wrote / the controller returned, per burst.
   logic [DW-1:0] wd [BL];
   logic [1:0]    ws [BL];
   logic [DW-1:0] exp_d [BL];
   logic [1:0]    exp_m [BL];
   int            exp_n;
   logic [AW-1:0] exp_waddr, exp_raddr;
   logic [DW-1:0] rd_ret [BL];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return sd_wr_req;
         1:       return sd_rd_req;
         2:       return u_if.wr_ready;
         default: return u_if.rd_aready;
      endcase
   endfunction

   task automatic wait_for(input int which, input string tag);
      int c = 0;
      while (sig(which) !== 1'b1 && c < 64) begin
         tick();
         c++;
      end
      chk(tag, 32'(sig(which)), 32'd1);
   endtask

   task automatic send_write(input logic [AW-1:0] addr, input int n, input bit with_rd,
                             input logic [AW-1:0] raddr);
      wait_for(2, "wr_ready_wait");
      for (int i = 0; i < n; i++) begin
         u_if.wr_valid = 1'b1;
         u_if.wr_data  = wd[i];
         u_if.wr_strb  = ws[i];
         u_if.wr_addr  = addr + AW'(i * 3);
         u_if.wr_last  = (i == n - 1) && (n < int'(BL));
         if (with_rd && i == n - 1) begin
            u_if.rd_avalid = 1'b1;
            u_if.rd_addr   = raddr;
            exp_raddr      = raddr;
         end
         tick();
      end
      u_if.wr_valid  = 1'b0;
      u_if.wr_last   = 1'b0;
      u_if.rd_avalid = 1'b0;
      exp_waddr = addr;
      exp_n     = n;
      for (int k = 0; k < int'(BL); k++) begin
         exp_d[k] = wd[k];
         exp_m[k] = (k < n) ? ~ws[k] : 2'b11;
      end
   endtask

   task automatic serve_write(input int stall);
      wait_for(0, "wr_req_wait");
      chk("wr_addr", 32'(sd_wr_addr), 32'(exp_waddr));
      chk("wr_oe_pre", 32'(sd_dq_oe), 32'd0);
      repeat (stall) begin
         tick();
         chk("wr_req_hold", 32'(sd_wr_req), 32'd1);
      end
      sd_wr_ack = 1'b1;
      tick();
      sd_wr_ack = 1'b0;
      chk("wr_oe_busy", 32'(sd_dq_oe), 32'd1);
      chk("wr_req_drop", 32'(sd_wr_req), 32'd0);
      chk("wr_ready_busy", 32'(u_if.wr_ready), 32'd0);
      for (int k = 0; k < int'(BL); k++) begin
         if (k < exp_n) chk("pop_data", 32'(sd_dq_o), 32'(exp_d[k]));
         chk("pop_dqm", 32'(sd_dqm_o), 32'(exp_m[k]));
         sd_wr_dvalid = 1'b1;
         tick();
         sd_wr_dvalid = 1'b0;
      end
      chk("pop_saturate", 32'(sd_dqm_o), 32'(exp_m[BL-1]));
      sd_wr_done = 1'b1;
      tick();
      sd_wr_done = 1'b0;
      chk("wr_oe_off", 32'(sd_dq_oe), 32'd0);
      chk("wr_ready_back", 32'(u_if.wr_ready), 32'd1);
   endtask

   task automatic issue_read(input logic [AW-1:0] addr);
      wait_for(3, "rd_aready_wait");
      u_if.rd_avalid = 1'b1;
      u_if.rd_addr   = addr;
      tick();
      u_if.rd_avalid = 1'b0;
      exp_raddr = addr;
   endtask

   task automatic serve_read(input int stall, input int extra);
      wait_for(1, "rd_req_wait");
      chk("rd_addr", 32'(sd_rd_addr), 32'(exp_raddr));
      repeat (stall) begin
         tick();
         chk("rd_req_hold", 32'(sd_rd_req), 32'd1);
      end
      sd_rd_ack = 1'b1;
      tick();
      sd_rd_ack = 1'b0;
      chk("rd_valid_fill", 32'(u_if.rd_valid), 32'd0);
      for (int k = 0; k < int'(BL) + extra; k++) begin
         sd_rd_dvalid = 1'b1;
         sd_dq_i      = (k < int'(BL)) ? rd_ret[k] : 16'hDEAD;
         tick();
      end
      sd_rd_dvalid = 1'b0;
      sd_rd_done   = 1'b1;
      tick();
      sd_rd_done = 1'b0;
   endtask

   task automatic drain(input int stall_beat);
      chk("rd_valid_start", 32'(u_if.rd_valid), 32'd1);
      for (int k = 0; k < int'(BL); k++) begin
         if (k == stall_beat) begin
            u_if.rd_ready = 1'b0;
            repeat (3) begin
               tick();
               chk("rd_hold_valid", 32'(u_if.rd_valid), 32'd1);
               chk("rd_hold_data", 32'(u_if.rd_data), 32'(rd_ret[k]));
            end
         end
         chk("rd_data", 32'(u_if.rd_data), 32'(rd_ret[k]));
         chk("rd_last", 32'(u_if.rd_last), 32'(k == int'(BL) - 1));
         u_if.rd_ready = 1'b1;
         tick();
         u_if.rd_ready = 1'b0;
      end
      chk("rd_valid_end", 32'(u_if.rd_valid), 32'd0);
      chk("rd_aready_end", 32'(u_if.rd_aready), 32'd1);
   endtask

   task automatic chk_reset_values();
      chk("rst_wr_ready", 32'(u_if.wr_ready), 32'd1);
      chk("rst_rd_aready", 32'(u_if.rd_aready), 32'd1);
      chk("rst_rd_valid", 32'(u_if.rd_valid), 32'd0);
      chk("rst_rd_last", 32'(u_if.rd_last), 32'd0);
      chk("rst_wr_req", 32'(sd_wr_req), 32'd0);
      chk("rst_rd_req", 32'(sd_rd_req), 32'd0);
      chk("rst_oe", 32'(sd_dq_oe), 32'd0);
      chk("rst_wr_addr", 32'(sd_wr_addr), 32'd0);
      chk("rst_rd_addr", 32'(sd_rd_addr), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         assert (!(sd_wr_req && sd_rd_req)) else begin
            bad++;
            $error("FAIL both_req: wr_req=%0b rd_req=%0b required not both high", sd_wr_req, sd_rd_req);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, observed no completion, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      u_if.wr_valid = 0; u_if.wr_data = '0; u_if.wr_strb = '0; u_if.wr_addr = '0; u_if.wr_last = 0;
      u_if.rd_avalid = 0; u_if.rd_addr = '0; u_if.rd_ready = 0;
      sd_wr_ack = 0; sd_wr_dvalid = 0; sd_wr_done = 0;
      sd_rd_ack = 0; sd_rd_dvalid = 0; sd_rd_done = 0; sd_dq_i = '0;

      repeat (3) tick();
      chk_reset_values();
      rst_n = 1'b1;
      tick();

      // Full 4-beat write
      wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
      for (int i = 0; i < int'(BL); i++) ws[i] = 2'b11;
      send_write(24'h000100, 4, 1'b0, '0);
      chk("wr_req_latency", 32'(sd_wr_req), 32'd1);
      chk("wr_ready_req", 32'(u_if.wr_ready), 32'd0);
      serve_write(2);

      // Early wr_last after two beats
      wd[0] = 16'hAAAA; wd[1] = 16'hBBBB;
      send_write(24'h000140, 2, 1'b0, '0);
      serve_write(0);

      // Read with an over-long controller burst and a mid-drain stall
      issue_read(24'h000200);
      for (int i = 0; i < int'(BL); i++) rd_ret[i] = 16'h5A00 + 16'(i);
      serve_read(1, 1);
      drain(2);

      // Two contested grants: read first, then write
      for (int i = 0; i < int'(BL); i++) begin
         wd[i] = 16'($urandom); ws[i] = 2'($urandom); rd_ret[i] = 16'($urandom);
      end
      send_write(24'h000300, 4, 1'b1, 24'h000400);
      chk("contest1_rd", 32'(sd_rd_req), 32'd1);
      chk("contest1_wr", 32'(sd_wr_req), 32'd0);
      serve_read(2, 0);
      serve_write(0);
      drain(-1);
      for (int i = 0; i < int'(BL); i++) begin
         wd[i] = 16'($urandom); ws[i] = 2'($urandom); rd_ret[i] = 16'($urandom);
      end
      send_write(24'h000500, 3, 1'b1, 24'h000600);
      chk("contest2_wr", 32'(sd_wr_req), 32'd1);
      chk("contest2_rd", 32'(sd_rd_req), 32'd0);
      serve_write(1);
      serve_read(0, 0);
      drain(-1);

      // Reset in the middle of a write burst after two pops
      for (int i = 0; i < int'(BL); i++) begin wd[i] = 16'($urandom); ws[i] = 2'b11; end
      send_write(24'h000700, 4, 1'b0, '0);
      wait_for(0, "wr_req_wait_rst");
      sd_wr_ack = 1'b1;
      tick();
      sd_wr_ack = 1'b0;
      repeat (2) begin
         sd_wr_dvalid = 1'b1;
         tick();
      end
      sd_wr_dvalid = 1'b0;
      rst_n = 1'b0;
      tick();
      chk_reset_values();
      rst_n = 1'b1;
      repeat (2) tick();
      chk("rst_abandon_req", 32'(sd_wr_req), 32'd0);
      for (int i = 0; i < int'(BL); i++) begin wd[i] = 16'h7000 + 16'(i); ws[i] = 2'b11; end
      send_write(24'h000800, 4, 1'b0, '0);
      serve_write(0);

      // Randomized write/read bursts
      for (int it = 0; it < 8; it++) begin
         int n;
         n = int'($urandom_range(1, BL));
         for (int i = 0; i < int'(BL); i++) begin
            wd[i] = 16'($urandom); ws[i] = 2'($urandom); rd_ret[i] = 16'($urandom);
         end
         send_write(AW'($urandom), n, 1'b0, '0);
         serve_write(int'($urandom_range(0, 2)));
         issue_read(AW'($urandom));
         serve_read(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
         drain(int'($urandom_range(0, BL)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
